// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4-channel mux scanner: settles DWELL cycles per channel and publishes a 4-bit word
`timescale 1ns/1ps

module mux_scan_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_o,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;
    logic       capture;

    assign capture = (state_q == S_SETTLE) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 4'd0;
            data_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                sel_d = 2'd0;
                cnt_d = 4'd0;
                if (start) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (capture) begin
                    shadow_d[sel_q] = mux_o;
                    cnt_d           = 4'd0;
                    // The last channel's bit is captured on the same edge that publishes the word.
                    if (sel_q == 2'd3) begin
                        state_d = S_DONE;
                        data_d  = shadow_d;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                sel_d   = 2'd0;
                cnt_d   = 4'd0;
                state_d = cont ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        sel  = sel_q;
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        data = data_q;
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed bench for mux_scan_ctrl with DWELL=2 and DWELL=1 instances
`timescale 1ns/1ps

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, cont2, mux2, busy2, done2;
    logic [3:0] in2, data2;
    logic [1:0] sel2;
    logic       start1, cont1, mux1, busy1, done1;
    logic [3:0] in1, data1;
    logic [1:0] sel1;
    int         total = 0;
    int         bad   = 0;
    logic       done2_prev = 1'b0;
    logic       done1_prev = 1'b0;

    always #5 clk = ~clk;

    assign mux2 = in2[sel2];
    assign mux1 = in1[sel1];

    mux_scan_ctrl #(.DWELL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .mux_o(mux2),
        .sel(sel2), .busy(busy2), .done(done2), .data(data2)
    );

    mux_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .mux_o(mux1),
        .sel(sel1), .busy(busy1), .done(done1), .data(data1)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        total++;
        if (done2 && !busy2) begin bad++; $display("FAIL mon_done_busy2 done=%0b busy=%0b", done2, busy2); end
        total++;
        if (!busy2 && sel2 !== 2'd0) begin bad++; $display("FAIL mon_idle_sel2 got=%0d exp=0", sel2); end
        total++;
        if (done2 && done2_prev) begin bad++; $display("FAIL mon_done_twice2 got=1 exp=0"); end
        total++;
        if (done1 && !busy1) begin bad++; $display("FAIL mon_done_busy1 done=%0b busy=%0b", done1, busy1); end
        total++;
        if (!busy1 && sel1 !== 2'd0) begin bad++; $display("FAIL mon_idle_sel1 got=%0d exp=0", sel1); end
        total++;
        if (done1 && done1_prev) begin bad++; $display("FAIL mon_done_twice1 got=1 exp=0"); end
        done2_prev = done2;
        done1_prev = done1;
    end

    task automatic test_reset;
        rst_n = 1'b1;
        start2 = 1'b0; cont2 = 1'b0; in2 = 4'd0;
        start1 = 1'b0; cont1 = 1'b0; in1 = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({sel2, busy2, done2, data2} !== 8'd0) begin
            bad++; $display("FAIL reset_dut2 got=%0h exp=0", {sel2, busy2, done2, data2});
        end
        total++;
        if ({sel1, busy1, done1, data1} !== 8'd0) begin
            bad++; $display("FAIL reset_dut1 got=%0h exp=0", {sel1, busy1, done1, data1});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step;
        total++;
        if (busy2 !== 1'b0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy2=%0b busy1=%0b exp=0", busy2, busy1);
        end
    endtask

    task automatic test_single_scan;
        in2 = 4'b1010;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (sel2 !== 2'(k / 2)) begin bad++; $display("FAIL single_sel edge=%0d got=%0d exp=%0d", k, sel2, k / 2); end
            total++;
            if (done2 !== 1'b0 || busy2 !== 1'b1) begin
                bad++; $display("FAIL single_flags edge=%0d done=%0b busy=%0b exp done=0 busy=1", k, done2, busy2);
            end
            total++;
            if (data2 !== 4'b0000) begin bad++; $display("FAIL single_data_hold edge=%0d got=%b exp=0000", k, data2); end
            step;
        end
        total++;
        if (done2 !== 1'b1 || busy2 !== 1'b1) begin
            bad++; $display("FAIL single_done done=%0b busy=%0b exp=1,1", done2, busy2);
        end
        total++;
        if (data2 !== 4'b1010) begin bad++; $display("FAIL single_data got=%b exp=1010", data2); end
        step;
        total++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || data2 !== 4'b1010) begin
            bad++; $display("FAIL single_after done=%0b busy=%0b data=%b exp 0,0,1010", done2, busy2, data2);
        end
    endtask

    task automatic test_start_held;
        int n;
        bit seen;
        n = 0;
        in2 = 4'b0101;
        start2 = 1'b1;
        step;
        for (int k = 1; k <= 9; k++) begin
            step;
            if (done2) n++;
        end
        total++;
        if (n !== 1) begin bad++; $display("FAIL held_done_count got=%0d exp=1", n); end
        total++;
        if (busy2 !== 1'b0 || sel2 !== 2'd0) begin
            bad++; $display("FAIL held_idle busy=%0b sel=%0d exp 0,0", busy2, sel2);
        end
        step;
        total++;
        if (busy2 !== 1'b1) begin bad++; $display("FAIL held_restart got=%0b exp=1", busy2); end
        start2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step;
            seen = done2;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL held_timeout got=0 exp=1"); end
        total++;
        if (data2 !== 4'b0101) begin bad++; $display("FAIL held_data got=%b exp=0101", data2); end
        step;
    endtask

    task automatic test_cont_toggle;
        in2 = 4'b0011;
        cont2 = 1'b1;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step;
            if (k == 3) cont2 = 1'b0;
        end
        total++;
        if (done2 !== 1'b1 || data2 !== 4'b0011) begin
            bad++; $display("FAIL cont_toggle_done done=%0b data=%b exp 1,0011", done2, data2);
        end
        step;
        total++;
        if (busy2 !== 1'b0) begin bad++; $display("FAIL cont_toggle_idle got=%0b exp=0", busy2); end
    endtask

    task automatic test_abort_reset;
        in2 = 4'b1111;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        repeat (8) step;
        total++;
        if (done2 !== 1'b1 || data2 !== 4'b1111) begin
            bad++; $display("FAIL abort_prior done=%0b data=%b exp 1,1111", done2, data2);
        end
        step;
        in2 = 4'b0000;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        repeat (4) step;
        total++;
        if (sel2 !== 2'd2) begin bad++; $display("FAIL abort_pre_sel got=%0d exp=2", sel2); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (data2 !== 4'd0 || sel2 !== 2'd0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            bad++; $display("FAIL abort_async data=%b sel=%0d busy=%0b done=%0b exp all 0", data2, sel2, busy2, done2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        total++;
        if (busy2 !== 1'b1 || sel2 !== 2'd0) begin
            bad++; $display("FAIL abort_first_edge busy=%0b sel=%0d exp 1,0", busy2, sel2);
        end
        repeat (7) step;
        total++;
        if (done2 !== 1'b0 || data2 !== 4'd0) begin
            bad++; $display("FAIL abort_no_done done=%0b data=%b exp 0,0000", done2, data2);
        end
        step;
        total++;
        if (done2 !== 1'b1 || data2 !== 4'b0000) begin
            bad++; $display("FAIL abort_rescan done=%0b data=%b exp 1,0000", done2, data2);
        end
        step;
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_data;
        logic [1:0] exp_sel;
        logic       exp_done;
        in1 = 4'b0110;
        cont1 = 1'b1;
        start1 = 1'b1;
        step;
        start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            exp_done = (c % 5 == 4);
            exp_sel  = exp_done ? 2'd3 : 2'(c % 5);
            exp_data = (c < 4) ? 4'b0000 : (c < 14) ? 4'b0110 : (c < 19) ? 4'b1010 : 4'b1001;
            total++;
            if (sel1 !== exp_sel) begin bad++; $display("FAIL b2b_sel edge=%0d got=%0d exp=%0d", c, sel1, exp_sel); end
            total++;
            if (done1 !== exp_done) begin bad++; $display("FAIL b2b_done edge=%0d got=%0b exp=%0b", c, done1, exp_done); end
            total++;
            if (data1 !== exp_data) begin bad++; $display("FAIL b2b_data edge=%0d got=%b exp=%b", c, data1, exp_data); end
            if (c == 12) in1 = 4'b1001;
            if (c == 15) cont1 = 1'b0;
            step;
        end
        total++;
        if (busy1 !== 1'b0 || sel1 !== 2'd0 || data1 !== 4'b1001) begin
            bad++; $display("FAIL b2b_end busy=%0b sel=%0d data=%b exp 0,0,1001", busy1, sel1, data1);
        end
    endtask

    initial begin
        test_reset;
        test_single_scan;
        test_start_held;
        test_cont_toggle;
        test_abort_reset;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
